traffic_light_multi: RTL and testbench
======================================

TRAFFIC_LIGHT_MULTI -- requirements
Module: traffic_light_multi

Interface
REQ-001 The block SHALL provide the following parameters:
  - N_DIR, default 4: number of approaches, range 2..8.
  - CNT_W, default 8: width of each queue count.
  - GREEN_T, default 5: cycles per green slot.
  - YELLOW_T, default 1: yellow cycles.
  - ALLRED_T, default 1: all-red cycles.
  - EXT_HI, default 4: maximum extra green slots at ratio >4.
  - EXT_LO, default 2: maximum extra green slots at ratio >2.
REQ-002 The block SHALL have the following ports, clock and reset first:
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  asynchronous, active-high.
  - queue  in  N_DIR*CNT_W  packed vehicle counts; approach i occupies bits [i*CNT_W +: CNT_W].
  - emerg_req  in  1  level request for emergency preemption.
  - emerg_dir  in  $clog2(N_DIR)  approach to serve while emerg_req is high.
  - lights  out  N_DIR*3  packed per-approach lamp code, approach i in [i*3 +: 3].
  - cur_dir  out  $clog2(N_DIR)  approach currently owning the phase.
  - emerg_active  out  1  high while the preemption green is held.

Function
REQ-003 Lamp codes SHALL be one-hot: green 3'b001, yellow 3'b010, red 3'b100; the owner approach shows its phase colour and every other approach shows red.
REQ-004 The FSM SHALL have four states:
  - GREEN: owner green.
  - YELLOW: owner yellow.
  - ALLRED: all approaches red.
  - EGREEN: emerg_dir green.
REQ-005 GREEN, YELLOW and ALLRED SHALL each last exactly GREEN_T, YELLOW_T and ALLRED_T cycles respectively, counted by a phase timer cleared on each state entry.
REQ-006 On the last GREEN cycle with q_cur > 4*q_nxt and ext < EXT_HI, the block SHALL stay in GREEN for another GREEN_T cycles and increment ext.
REQ-007 Otherwise, if q_cur > 2*q_nxt and ext < EXT_LO, the block SHALL extend in the same way.
REQ-008 Otherwise the block SHALL go to YELLOW and clear ext.
REQ-009 Ratio comparisons SHALL use shift-multiplied q_nxt at CNT_W+3 bits with no division; q_nxt = 0 with q_cur > 0 therefore extends, and q_cur = 0 never extends.
REQ-010 nxt SHALL be the first approach after cur_dir in round-robin order (wrapping N_DIR-1 to 0) with a nonzero count; if all other approaches are zero, nxt SHALL be (cur_dir+1) mod N_DIR.
REQ-011 nxt SHALL be sampled at the GREEN-to-YELLOW transition, held, and loaded into cur_dir at ALLRED exit, which enters GREEN.
REQ-012 When emerg_req is sampled high in GREEN or YELLOW and cur_dir != emerg_dir, the block SHALL go to YELLOW (from GREEN immediately, with timer cleared) and then ALLRED; at ALLRED exit it SHALL enter EGREEN with cur_dir = emerg_dir.
REQ-013 When emerg_req is sampled high in GREEN with cur_dir == emerg_dir, the block SHALL move to EGREEN without a yellow phase.
REQ-014 A request raised during ALLRED SHALL take effect at ALLRED exit.
REQ-015 In EGREEN, emerg_active SHALL be 1 and the block SHALL hold as long as emerg_req is high; on the first low sample it SHALL go to YELLOW with nxt computed per REQ-010.
REQ-016 In EGREEN, changes on emerg_dir SHALL be ignored.
REQ-017 ext SHALL be cleared on entry to EGREEN.
REQ-018 An emerg_dir value >= N_DIR SHALL be ignored, with no preemption.
REQ-019 When emerg_req and the GREEN extension decision coincide, preemption SHALL win.
REQ-020 lights, cur_dir and emerg_active SHALL be decoded combinationally from registered state only, with no input-to-output combinational path.

Reset
REQ-021 Asserting reset SHALL immediately force: state GREEN, cur_dir 0, timer 0, ext 0, latched nxt 0.
REQ-022 While reset is asserted, lights SHALL show approach 0 green and all others red, and emerg_active SHALL be 0.
REQ-023 Reset asserted mid-phase, including in EGREEN, SHALL abort the phase with no yellow or all-red.
REQ-024 After reset deasserts, the first GREEN SHALL last the full GREEN_T cycles.

Structure
REQ-025 Lamp encodings and the state enum SHALL live in package traffic_light_pkg.
REQ-026 The round-robin nonzero-demand search SHALL be a combinational sub-module tl_next_dir, parameterised by N_DIR and CNT_W.
REQ-027 Timer width SHALL be sized to max(GREEN_T, YELLOW_T, ALLRED_T); ext width SHALL be sized to EXT_HI.

Verification
REQ-028 Defaults, all queues 10, no emergency -> each approach gets 5 green, 1 yellow and 1 all-red cycle, in order 0,1,2,3,0.
REQ-029 queue0=50, queue1=10, others 0 -> approach 0 green for 25 cycles (4 extensions), then hands to approach 1; approaches 2 and 3 are skipped.
REQ-030 queue0=25, queue1=10 -> 15 green cycles (2 extensions); queue0=20, queue1=10 -> 5 green cycles (no extension, since 20 is not > 20).
REQ-031 Approach 2 green at cycle 2 of GREEN, emerg_req=1 with emerg_dir=0 -> next cycle yellow on 2, then all-red, then approach 0 green with emerg_active=1 until emerg_req drops, then yellow on 0.
REQ-032 Reset pulse during EGREEN or YELLOW -> lights = approach 0 green immediately and asynchronously, followed by a full 5-cycle green.
REQ-033 All queues 0 -> plain round robin 0,1,2,3 with no extensions; with N_DIR=2, the ALLRED exit wraps from approach 1 to approach 0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// ---------------------------------------------------------------------------
// traffic_light_pkg
// Shared definitions for the multi-approach traffic light controller:
//   - tl_state_e : phase state of the controller FSM
//   - LAMP_*     : one-hot lamp codes driven per approach
//   - max3()     : elaboration helper used to size the phase timer
// ---------------------------------------------------------------------------
package traffic_light_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,  // owner approach green
    ST_YELLOW = 2'd1,  // owner approach yellow
    ST_ALLRED = 2'd2,  // every approach red
    ST_EGREEN = 2'd3   // emergency approach held green
  } tl_state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tl_next_dir.sv
// ---------------------------------------------------------------------------
// tl_next_dir
// Combinational round-robin search: starting after the current owner, return
// the first approach with a nonzero vehicle count. When every other approach
// is empty the plain successor (cur+1 mod N_DIR) is returned.
// Ports:
//   i_queue : packed counts, approach i at [i*CNT_W +: CNT_W]
//   i_cur   : current owner approach
//   o_nxt   : selected next approach
// ---------------------------------------------------------------------------
module tl_next_dir
  import traffic_light_pkg::*;
#(
  parameter int N_DIR = 4,
  parameter int CNT_W = 8,
  localparam int DIR_W = $clog2(N_DIR)
) (
  input  logic [N_DIR*CNT_W-1:0] i_queue,
  input  logic [DIR_W-1:0]       i_cur,
  output logic [DIR_W-1:0]       o_nxt
);

  logic [CNT_W-1:0] w_q [N_DIR];
  logic             w_found;
  logic [DIR_W-1:0] w_idx;

  for (genvar g = 0; g < N_DIR; g++) begin : g_unpack
    assign w_q[g] = i_queue[g*CNT_W +: CNT_W];
  end

  // Offsets 1..N_DIR-1 walk the ring once, never revisiting the owner.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    o_nxt   = DIR_W'((32'(i_cur) + 32'd1) % N_DIR);
    for (int k = 1; k < N_DIR; k++) begin
      w_idx = DIR_W'((32'(i_cur) + 32'(k)) % N_DIR);
      if (!w_found && (w_q[w_idx] != '0)) begin
        o_nxt   = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_multi.sv
// ---------------------------------------------------------------------------
// traffic_light_multi
// Demand-aware round-robin traffic light for N_DIR approaches with green
// extension on heavy queues and level-sensitive emergency preemption.
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous, active-high; forces approach 0 green
//   queue        : packed vehicle counts, approach i at [i*CNT_W +: CNT_W]
//   emerg_req    : level request for emergency preemption
//   emerg_dir    : approach to serve while emerg_req is high
//   lights       : packed one-hot lamp code per approach, approach i at [i*3 +: 3]
//   cur_dir      : approach currently owning the phase
//   emerg_active : high while the preemption green is held
// All outputs decode from registered state only.
// ---------------------------------------------------------------------------
module traffic_light_multi
  import traffic_light_pkg::*;
#(
  parameter int N_DIR    = 4,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int EXT_HI   = 4,
  parameter int EXT_LO   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_DIR*CNT_W-1:0]     queue,
  input  logic                       emerg_req,
  input  logic [$clog2(N_DIR)-1:0]   emerg_dir,
  output logic [N_DIR*3-1:0]         lights,
  output logic [$clog2(N_DIR)-1:0]   cur_dir,
  output logic                       emerg_active
);

  localparam int DIR_W = $clog2(N_DIR);
  localparam int TMR_W = $clog2(max3(GREEN_T, YELLOW_T, ALLRED_T) + 1);
  localparam int EXT_W = $clog2(EXT_HI + 1);
  localparam int CMP_W = CNT_W + 3;

  tl_state_e        r_state, w_state_nxt;
  logic [DIR_W-1:0] r_cur, w_cur_nxt;
  logic [DIR_W-1:0] r_nxt, w_nxt_latch;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [EXT_W-1:0] r_ext, w_ext_nxt;

  logic [DIR_W-1:0] w_rr_nxt;
  logic [CNT_W-1:0] w_q [N_DIR];
  logic [CMP_W-1:0] w_q_cur, w_q_nxt_x2, w_q_nxt_x4;
  logic             w_emerg_ok, w_ext_hi, w_ext_lo;
  logic             w_green_done, w_yellow_done, w_allred_done;
  logic [2:0]       w_lamp;

  for (genvar g = 0; g < N_DIR; g++) begin : g_unpack
    assign w_q[g] = queue[g*CNT_W +: CNT_W];
  end

  tl_next_dir #(
    .N_DIR (N_DIR),
    .CNT_W (CNT_W)
  ) u_next_dir (
    .i_queue (queue),
    .i_cur   (r_cur),
    .o_nxt   (w_rr_nxt)
  );

  // Requests naming a non-existent approach are dropped entirely.
  assign w_emerg_ok = emerg_req && (32'(emerg_dir) < N_DIR);

  // Ratio tests as shifts at CNT_W+3 bits, so 4*q_nxt cannot overflow.
  assign w_q_cur    = {3'b000, w_q[r_cur]};
  assign w_q_nxt_x2 = {2'b00, w_q[w_rr_nxt], 1'b0};
  assign w_q_nxt_x4 = {1'b0, w_q[w_rr_nxt], 2'b00};
  assign w_ext_hi   = (w_q_cur > w_q_nxt_x4) && (r_ext < EXT_W'(EXT_HI));
  assign w_ext_lo   = (w_q_cur > w_q_nxt_x2) && (r_ext < EXT_W'(EXT_LO));

  assign w_green_done  = (r_timer == TMR_W'(GREEN_T - 1));
  assign w_yellow_done = (r_timer == TMR_W'(YELLOW_T - 1));
  assign w_allred_done = (r_timer == TMR_W'(ALLRED_T - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_GREEN;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_timer <= '0;
      r_ext   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_nxt   <= w_nxt_latch;
      r_timer <= w_timer_nxt;
      r_ext   <= w_ext_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_nxt_latch = r_nxt;
    w_timer_nxt = r_timer + 1'b1;
    w_ext_nxt   = r_ext;
    unique case (r_state)
      ST_GREEN: begin
        // Preemption is checked first so it beats any extension decision.
        if (w_emerg_ok) begin
          w_timer_nxt = '0;
          w_ext_nxt   = '0;
          if (emerg_dir == r_cur) begin
            w_state_nxt = ST_EGREEN;
          end else begin
            w_state_nxt = ST_YELLOW;
            w_nxt_latch = w_rr_nxt;
          end
        end else if (w_green_done) begin
          w_timer_nxt = '0;
          if (w_ext_hi || w_ext_lo) begin
            w_ext_nxt = r_ext + 1'b1;
          end else begin
            w_state_nxt = ST_YELLOW;
            w_ext_nxt   = '0;
            w_nxt_latch = w_rr_nxt;
          end
        end
      end
      ST_YELLOW: begin
        if (w_yellow_done) begin
          w_state_nxt = ST_ALLRED;
          w_timer_nxt = '0;
        end
      end
      ST_ALLRED: begin
        // A request still (or newly) present here decides the next owner.
        if (w_allred_done) begin
          w_timer_nxt = '0;
          if (w_emerg_ok) begin
            w_state_nxt = ST_EGREEN;
            w_cur_nxt   = emerg_dir;
            w_ext_nxt   = '0;
          end else begin
            w_state_nxt = ST_GREEN;
            w_cur_nxt   = r_nxt;
          end
        end
      end
      ST_EGREEN: begin
        // Timer parked at zero: the hold length is unbounded.
        w_timer_nxt = '0;
        if (!emerg_req) begin
          w_state_nxt = ST_YELLOW;
          w_nxt_latch = w_rr_nxt;
        end
      end
      default: begin
        w_state_nxt = ST_GREEN;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_lamp = LAMP_RED;
    unique case (r_state)
      ST_GREEN, ST_EGREEN: w_lamp = LAMP_GREEN;
      ST_YELLOW:           w_lamp = LAMP_YELLOW;
      default:             w_lamp = LAMP_RED;
    endcase
    for (int i = 0; i < N_DIR; i++) begin
      lights[i*3 +: 3] = (DIR_W'(i) == r_cur) ? w_lamp : LAMP_RED;
    end
    cur_dir      = r_cur;
    emerg_active = (r_state == ST_EGREEN);
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_multi
// Directed bench for traffic_light_multi: default 4-approach instance plus a
// 2-approach instance (ring wrap) and a 3-approach instance (out-of-range
// emergency direction). Outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_multi;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic        clock;
  logic        reset;
  logic [31:0] queue;
  logic        emerg_req;
  logic [1:0]  emerg_dir;
  logic [11:0] lights;
  logic [1:0]  cur_dir;
  logic        emerg_active;

  logic [15:0] queue2;
  logic        er2;
  logic [0:0]  ed2;
  logic [5:0]  lights2;
  logic [0:0]  cur2;
  logic        ea2;

  logic [23:0] queue3;
  logic        er3;
  logic [1:0]  ed3;
  logic [8:0]  lights3;
  logic [1:0]  cur3;
  logic        ea3;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_multi u_dut (
    .clock(clock), .reset(reset), .queue(queue), .emerg_req(emerg_req),
    .emerg_dir(emerg_dir), .lights(lights), .cur_dir(cur_dir),
    .emerg_active(emerg_active)
  );

  traffic_light_multi #(.N_DIR(2)) u_dut2 (
    .clock(clock), .reset(reset), .queue(queue2), .emerg_req(er2),
    .emerg_dir(ed2), .lights(lights2), .cur_dir(cur2), .emerg_active(ea2)
  );

  traffic_light_multi #(.N_DIR(3)) u_dut3 (
    .clock(clock), .reset(reset), .queue(queue3), .emerg_req(er3),
    .emerg_dir(ed3), .lights(lights3), .cur_dir(cur3), .emerg_active(ea3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] lamps(input int n, input int dir, input logic [2:0] code);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*3 +: 3] = (i == dir) ? code : R;
    return r;
  endfunction

  task automatic set_q(input int a0, input int a1, input int a2, input int a3);
    queue = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endtask

  task automatic chk4(input string tag, input int dir, input logic [2:0] code, input logic ea);
    logic [23:0] e;
    e = lamps(4, dir, code);
    n_assert++;
    assert (lights === e[11:0] && cur_dir === 2'(dir) && emerg_active === ea) else begin
      n_fail++;
      $error("FAIL %s @%0t: lights=%b cur_dir=%0d emerg_active=%b, expected lights=%b cur_dir=%0d emerg_active=%b",
             tag, $time, lights, cur_dir, emerg_active, e[11:0], dir, ea);
    end
  endtask

  task automatic chk2(input string tag, input int dir, input logic [2:0] code);
    logic [23:0] e;
    e = lamps(2, dir, code);
    n_assert++;
    assert (lights2 === e[5:0] && cur2 === 1'(dir) && ea2 === 1'b0) else begin
      n_fail++;
      $error("FAIL %s @%0t: lights=%b cur_dir=%0d emerg_active=%b, expected lights=%b cur_dir=%0d emerg_active=0",
             tag, $time, lights2, cur2, ea2, e[5:0], dir);
    end
  endtask

  task automatic chk3(input string tag, input int dir, input logic [2:0] code);
    logic [23:0] e;
    e = lamps(3, dir, code);
    n_assert++;
    assert (lights3 === e[8:0] && cur3 === 2'(dir) && ea3 === 1'b0) else begin
      n_fail++;
      $error("FAIL %s @%0t: lights=%b cur_dir=%0d emerg_active=%b, expected lights=%b cur_dir=%0d emerg_active=0",
             tag, $time, lights3, cur3, ea3, e[8:0], dir);
    end
  endtask

  task automatic exp4(input string tag, input int dir, input logic [2:0] code, input logic ea, input int n);
    for (int k = 0; k < n; k++) begin
      chk4(tag, dir, code, ea);
      @(posedge clock); #1;
    end
  endtask

  task automatic exp2(input string tag, input int dir, input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      chk2(tag, dir, code);
      @(posedge clock); #1;
    end
  endtask

  task automatic exp3(input string tag, input int dir, input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) begin
      chk3(tag, dir, code);
      @(posedge clock); #1;
    end
  endtask

  // Assert reset, check the forced state immediately and again just before
  // release, then release at a falling edge so the next sample is green cycle 1.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk4(tag, 0, G, 1'b0);
    @(negedge clock);
    chk4(tag, 0, G, 1'b0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    emerg_req = 1'b0;
    emerg_dir = 2'd0;
    set_q(10, 10, 10, 10);
    queue2 = '0;
    er2    = 1'b0;
    ed2    = 1'b0;
    queue3 = {8'd10, 8'd10, 8'd10};
    er3    = 1'b1;
    ed3    = 2'd3;

    // Equal demand: 5 green / 1 yellow / 1 all-red per approach, 0..3 then 0
    do_reset("rst_init");
    for (int d = 0; d < 4; d++) begin
      exp4("rr_green", d, G, 1'b0, 5);
      exp4("rr_yellow", d, Y, 1'b0, 1);
      exp4("rr_allred", d, R, 1'b0, 1);
    end
    exp4("rr_wrap", 0, G, 1'b0, 1);

    // Heavy approach 0: four high-ratio extensions, empty approaches skipped
    set_q(50, 10, 0, 0);
    do_reset("rst_t2");
    exp4("ext4_green", 0, G, 1'b0, 25);
    exp4("ext4_yellow", 0, Y, 1'b0, 1);
    exp4("ext4_allred", 0, R, 1'b0, 1);
    exp4("ext4_dir1", 1, G, 1'b0, 5);
    exp4("ext4_dir1_y", 1, Y, 1'b0, 1);
    exp4("ext4_dir1_ar", 1, R, 1'b0, 1);
    exp4("ext4_skip23", 0, G, 1'b0, 1);

    // Low-ratio extensions and the strict-inequality boundary
    set_q(25, 10, 0, 0);
    do_reset("rst_t3a");
    exp4("ext2_green", 0, G, 1'b0, 15);
    exp4("ext2_yellow", 0, Y, 1'b0, 1);
    set_q(20, 10, 0, 0);
    do_reset("rst_t3b");
    exp4("ext0_green", 0, G, 1'b0, 5);
    exp4("ext0_yellow", 0, Y, 1'b0, 1);

    // Empty next approach extends; empty owner never extends
    set_q(5, 0, 0, 0);
    do_reset("rst_t3c");
    exp4("qn0_green", 0, G, 1'b0, 25);
    exp4("qn0_yellow", 0, Y, 1'b0, 1);
    exp4("qn0_allred", 0, R, 1'b0, 1);
    exp4("qc0_green", 1, G, 1'b0, 5);
    exp4("qc0_yellow", 1, Y, 1'b0, 1);

    // Preemption from approach 2 to approach 0, emerg_dir change ignored
    set_q(10, 10, 10, 10);
    do_reset("rst_t4");
    exp4("pre_g0", 0, G, 1'b0, 5);
    exp4("pre_y0", 0, Y, 1'b0, 1);
    exp4("pre_ar0", 0, R, 1'b0, 1);
    exp4("pre_g1", 1, G, 1'b0, 5);
    exp4("pre_y1", 1, Y, 1'b0, 1);
    exp4("pre_ar1", 1, R, 1'b0, 1);
    exp4("pre_g2c1", 2, G, 1'b0, 1);
    emerg_req = 1'b1;
    emerg_dir = 2'd0;
    exp4("pre_g2c2", 2, G, 1'b0, 1);
    exp4("pre_y2", 2, Y, 1'b0, 1);
    exp4("pre_ar2", 2, R, 1'b0, 1);
    exp4("pre_eg0", 0, G, 1'b1, 2);
    emerg_dir = 2'd3;
    exp4("pre_eg0_dirchg", 0, G, 1'b1, 2);
    emerg_req = 1'b0;
    exp4("pre_eg0_last", 0, G, 1'b1, 1);
    exp4("pre_exit_y0", 0, Y, 1'b0, 1);
    exp4("pre_exit_ar0", 0, R, 1'b0, 1);
    exp4("pre_exit_g1", 1, G, 1'b0, 1);

    // Preemption on the owner: no yellow; reset aborts EGREEN and YELLOW
    emerg_dir = 2'd0;
    do_reset("rst_t5");
    exp4("own_g0c1", 0, G, 1'b0, 1);
    emerg_req = 1'b1;
    exp4("own_g0c2", 0, G, 1'b0, 1);
    exp4("own_eg0", 0, G, 1'b1, 2);
    emerg_req = 1'b0;
    do_reset("rst_in_egreen");
    exp4("post_rst_green", 0, G, 1'b0, 5);
    chk4("post_rst_yellow", 0, Y, 1'b0);
    do_reset("rst_in_yellow");
    exp4("post_rst2_green", 0, G, 1'b0, 5);
    exp4("post_rst2_yellow", 0, Y, 1'b0, 1);

    // Preemption coinciding with an extension decision wins
    set_q(50, 10, 0, 0);
    do_reset("rst_t6");
    exp4("win_g0", 0, G, 1'b0, 4);
    emerg_req = 1'b1;
    emerg_dir = 2'd2;
    exp4("win_g0_last", 0, G, 1'b0, 1);
    exp4("win_y0", 0, Y, 1'b0, 1);
    exp4("win_ar0", 0, R, 1'b0, 1);
    exp4("win_eg2", 2, G, 1'b1, 1);
    emerg_req = 1'b0;
    exp4("win_eg2_last", 2, G, 1'b1, 1);
    exp4("win_y2", 2, Y, 1'b0, 1);
    exp4("win_ar2", 2, R, 1'b0, 1);
    exp4("win_g0_next", 0, G, 1'b0, 1);

    // Request raised during all-red takes effect at its exit
    set_q(10, 10, 10, 10);
    do_reset("rst_t7");
    exp4("ar_req_g0", 0, G, 1'b0, 5);
    exp4("ar_req_y0", 0, Y, 1'b0, 1);
    emerg_req = 1'b1;
    emerg_dir = 2'd3;
    exp4("ar_req_ar0", 0, R, 1'b0, 1);
    exp4("ar_req_eg3", 3, G, 1'b1, 1);
    emerg_req = 1'b0;
    exp4("ar_req_eg3_last", 3, G, 1'b1, 1);
    exp4("ar_req_y3", 3, Y, 1'b0, 1);
    exp4("ar_req_ar3", 3, R, 1'b0, 1);
    exp4("ar_req_wrap0", 0, G, 1'b0, 1);

    // All queues empty: plain round robin, no extensions
    set_q(0, 0, 0, 0);
    do_reset("rst_t8");
    for (int d = 0; d < 4; d++) begin
      exp4("zero_green", d, G, 1'b0, 5);
      exp4("zero_yellow", d, Y, 1'b0, 1);
      exp4("zero_allred", d, R, 1'b0, 1);
    end
    exp4("zero_wrap", 0, G, 1'b0, 1);

    // Two approaches: all-red exit wraps 1 -> 0
    do_reset("rst_n2");
    for (int d = 0; d < 2; d++) begin
      exp2("n2_green", d, G, 5);
      exp2("n2_yellow", d, Y, 1);
      exp2("n2_allred", d, R, 1);
    end
    exp2("n2_wrap", 0, G, 1);

    // Three approaches with emerg_dir=3 held high: request ignored
    do_reset("rst_n3");
    exp3("n3_green", 0, G, 5);
    exp3("n3_yellow", 0, Y, 1);
    exp3("n3_allred", 0, R, 1);
    exp3("n3_g1", 1, G, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
